// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 core controller: FSM encodings,
// datapath widths and small helpers used by the controller and its interface.
`default_nettype none

package aes_pkg;

    localparam int          AES_BLOCK_W   = 128;
    localparam int          AES_WORD_W    = 32;
    localparam int          TMO_W         = 8;
    localparam logic [3:0]  AES128_ROUNDS = 4'ha;

    typedef enum logic [2:0] {
        CTRL_IDLE      = 3'd0,
        CTRL_KEY_START = 3'd1,
        CTRL_KEY_WAIT  = 3'd2,
        CTRL_ENC_START = 3'd3,
        CTRL_ENC_WAIT  = 3'd4
    } ctrl_state_e;

    // Key expansion owns the shared S-box for its whole start/wait window.
    function automatic logic key_owns_sbox(input ctrl_state_e state);
        return (state == CTRL_KEY_START) || (state == CTRL_KEY_WAIT);
    endfunction

    function automatic logic is_wait_state(input ctrl_state_e state);
        return (state == CTRL_KEY_WAIT) || (state == CTRL_ENC_WAIT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_core_ctrl_if.sv
// Host and downstream handshake bundle for the AES-128 core controller.
// The slave modport is the controller's view, master is the environment's.
`default_nettype none

interface aes_core_ctrl_if;
    import aes_pkg::*;

    // host side
    logic                   init;
    logic                   next;
    logic                   ready;
    logic                   result_valid;
    logic                   cmd_err;
    logic [AES_BLOCK_W-1:0] result;

    // key memory / encipher / S-box side
    logic                   key_init;
    logic                   key_ready;
    logic                   enc_next;
    logic                   enc_ready;
    logic [AES_BLOCK_W-1:0] enc_new_block;
    logic [AES_WORD_W-1:0]  key_sboxw;
    logic [AES_WORD_W-1:0]  enc_sboxw;
    logic [AES_WORD_W-1:0]  sboxw;

    modport slave (
        input  init,
        input  next,
        input  key_ready,
        input  enc_ready,
        input  enc_new_block,
        input  key_sboxw,
        input  enc_sboxw,
        output ready,
        output result_valid,
        output cmd_err,
        output result,
        output key_init,
        output enc_next,
        output sboxw
    );

    modport master (
        output init,
        output next,
        output key_ready,
        output enc_ready,
        output enc_new_block,
        output key_sboxw,
        output enc_sboxw,
        input  ready,
        input  result_valid,
        input  cmd_err,
        input  result,
        input  key_init,
        input  enc_next,
        input  sboxw
    );

endinterface

`default_nettype wire

// File: rtl/aes_sbox_mux.sv
// 2:1 requester select in front of the single shared 32-bit S-box.
`default_nettype none

module aes_sbox_mux #(
    parameter int WORD_W = 32
) (
    input  wire logic              sel_key_i,
    input  wire logic [WORD_W-1:0] key_sboxw_i,
    input  wire logic [WORD_W-1:0] enc_sboxw_i,
    output logic      [WORD_W-1:0] sboxw_o
);

    always_comb begin
        sboxw_o = enc_sboxw_i;
        if (sel_key_i) begin
            sboxw_o = key_sboxw_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/aes_core_ctrl.sv
// AES-128 core sequencer: runs key expansion then encryption on host command,
// captures the ciphertext, aborts stuck downstream blocks and shares the S-box.
`default_nettype none

module aes_core_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic       clk,
    input  wire logic       reset,
    aes_core_ctrl_if.slave  ctrl_bus
);
    import aes_pkg::*;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    ctrl_state_e              state_q;
    logic                     key_valid_q;
    logic                     pending_q;
    logic                     result_valid_q;
    logic                     cmd_err_q;
    logic                     key_init_q;
    logic                     enc_next_q;
    logic [AES_BLOCK_W-1:0]   result_q;
    logic [TMO_W-1:0]         tmo_cnt_q;
    logic [TMO_W-1:0]         tmo_cnt_d;

    logic                     is_idle;
    logic                     busy_next_ok;
    logic                     busy_cmd_err;
    logic                     pending_hit;
    logic                     tmo_expired;
    logic                     sel_key;
    logic [AES_WORD_W-1:0]    sboxw;

    assign is_idle      = (state_q == CTRL_IDLE);
    assign busy_next_ok = !is_idle && ctrl_bus.next && !pending_q;
    assign busy_cmd_err = !is_idle && (ctrl_bus.init || (ctrl_bus.next && pending_q));
    // A next landing in the completion cycle is chained, not stranded in IDLE.
    assign pending_hit  = pending_q || busy_next_ok;
    assign tmo_expired  = (tmo_cnt_q == TMO_LAST);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if ((state_q == CTRL_KEY_START) || (state_q == CTRL_ENC_START)) begin
            tmo_cnt_d = '0;
        end else if (is_wait_state(state_q) && !tmo_expired) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= CTRL_IDLE;
            key_valid_q    <= 1'b0;
            pending_q      <= 1'b0;
            result_valid_q <= 1'b0;
            cmd_err_q      <= 1'b0;
            key_init_q     <= 1'b0;
            enc_next_q     <= 1'b0;
            result_q       <= '0;
            tmo_cnt_q      <= '0;
        end else begin
            cmd_err_q  <= 1'b0;
            key_init_q <= 1'b0;
            enc_next_q <= 1'b0;
            tmo_cnt_q  <= tmo_cnt_d;

            if (busy_next_ok) begin
                pending_q <= 1'b1;
            end
            if (busy_cmd_err) begin
                cmd_err_q <= 1'b1;
            end

            case (state_q)
                CTRL_IDLE: begin
                    if (ctrl_bus.init) begin
                        state_q    <= CTRL_KEY_START;
                        key_init_q <= 1'b1;
                        pending_q  <= ctrl_bus.next;
                    end else if (ctrl_bus.next) begin
                        if (key_valid_q) begin
                            state_q    <= CTRL_ENC_START;
                            enc_next_q <= 1'b1;
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                end

                CTRL_KEY_START: begin
                    key_valid_q    <= 1'b0;
                    result_valid_q <= 1'b0;
                    state_q        <= CTRL_KEY_WAIT;
                end

                CTRL_KEY_WAIT: begin
                    if (ctrl_bus.key_ready) begin
                        key_valid_q <= 1'b1;
                        if (pending_hit) begin
                            pending_q  <= 1'b0;
                            enc_next_q <= 1'b1;
                            state_q    <= CTRL_ENC_START;
                        end else begin
                            state_q <= CTRL_IDLE;
                        end
                    end else if (tmo_expired) begin
                        cmd_err_q   <= 1'b1;
                        pending_q   <= 1'b0;
                        key_valid_q <= 1'b0;
                        state_q     <= CTRL_IDLE;
                    end
                end

                CTRL_ENC_START: begin
                    result_valid_q <= 1'b0;
                    state_q        <= CTRL_ENC_WAIT;
                end

                CTRL_ENC_WAIT: begin
                    if (ctrl_bus.enc_ready) begin
                        result_q       <= ctrl_bus.enc_new_block;
                        result_valid_q <= 1'b1;
                        if (pending_hit) begin
                            pending_q  <= 1'b0;
                            enc_next_q <= 1'b1;
                            state_q    <= CTRL_ENC_START;
                        end else begin
                            state_q <= CTRL_IDLE;
                        end
                    end else if (tmo_expired) begin
                        cmd_err_q <= 1'b1;
                        pending_q <= 1'b0;
                        state_q   <= CTRL_IDLE;
                    end
                end

                default: begin
                    state_q <= CTRL_IDLE;
                end
            endcase
        end
    end

    assign sel_key = key_owns_sbox(state_q);

    aes_sbox_mux #(
        .WORD_W (AES_WORD_W)
    ) u_sbox_mux (
        .sel_key_i   (sel_key),
        .key_sboxw_i (ctrl_bus.key_sboxw),
        .enc_sboxw_i (ctrl_bus.enc_sboxw),
        .sboxw_o     (sboxw)
    );

    assign ctrl_bus.sboxw        = sboxw;
    assign ctrl_bus.ready        = is_idle && !pending_q;
    assign ctrl_bus.result_valid = result_valid_q;
    assign ctrl_bus.cmd_err      = cmd_err_q;
    assign ctrl_bus.result       = result_q;
    assign ctrl_bus.key_init     = key_init_q;
    assign ctrl_bus.enc_next     = enc_next_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_core_ctrl.sv
// Directed bench for aes_core_ctrl with behavioural key-memory and encipher models.
`default_nettype none

module tb_aes_core_ctrl;

    localparam logic [127:0] FIPS_CT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    aes_core_ctrl_if bus ();

    aes_core_ctrl #(
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ctrl_bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int key_lat = 20;
    int enc_lat = 52;
    bit key_hang = 1'b0;
    bit enc_hang = 1'b0;
    logic [127:0] blk_vec = FIPS_CT;
    int kcnt = 0;
    int ecnt = 0;

    // key memory model: ready drops after key_init, rises after key_lat cycles
    always @(posedge clk) begin
        if (reset) begin
            bus.key_ready <= 1'b1;
            kcnt <= 0;
        end else if (bus.key_init) begin
            bus.key_ready <= 1'b0;
            kcnt <= key_lat;
        end else if (kcnt != 0 && !key_hang) begin
            if (kcnt == 1) bus.key_ready <= 1'b1;
            kcnt <= kcnt - 1;
        end
    end

    // encipher model: block presented together with enc_ready
    always @(posedge clk) begin
        if (reset) begin
            bus.enc_ready <= 1'b1;
            bus.enc_new_block <= '0;
            ecnt <= 0;
        end else if (bus.enc_next) begin
            bus.enc_ready <= 1'b0;
            bus.enc_new_block <= ~blk_vec;
            ecnt <= enc_lat;
        end else if (ecnt != 0 && !enc_hang) begin
            if (ecnt == 1) begin
                bus.enc_ready <= 1'b1;
                bus.enc_new_block <= blk_vec;
            end
            ecnt <= ecnt - 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=2000000", $time);
        $fatal(1);
    end

    task automatic drive_cmd(input logic i, input logic n);
        @(negedge clk);
        bus.init = i;
        bus.next = n;
        @(negedge clk);
        bus.init = 1'b0;
        bus.next = 1'b0;
    endtask

    task automatic wait_ready(input int max_cycles);
        int n = 0;
        while (bus.ready !== 1'b1 && n < max_cycles) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.init = 1'b0;
        bus.next = 1'b0;
        bus.key_sboxw = 32'hdeadbeef;
        bus.enc_sboxw = 32'h01234567;
        repeat (3) @(negedge clk);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid: got %b want 0", bus.result_valid); end
        checks++; if (bus.cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err: got %b want 0", bus.cmd_err); end
        checks++; if (bus.result !== 128'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result); end
        checks++; if (bus.key_init !== 1'b0 || bus.enc_next !== 1'b0) begin errors++; $display("FAIL reset_pulses: got key_init=%b enc_next=%b want 0 0", bus.key_init, bus.enc_next); end
        checks++; if (bus.sboxw !== 32'h01234567) begin errors++; $display("FAIL reset_sboxw: got %h want 01234567", bus.sboxw); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_next_no_key();
        int en = 0;
        drive_cmd(1'b0, 1'b1);
        checks++; if (bus.cmd_err !== 1'b1) begin errors++; $display("FAIL nokey_cmd_err: got %b want 1", bus.cmd_err); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL nokey_ready: got %b want 1", bus.ready); end
        for (int i = 0; i < 5; i++) begin
            if (bus.enc_next === 1'b1) en++;
            @(negedge clk);
        end
        checks++; if (en != 0) begin errors++; $display("FAIL nokey_enc_next: got %0d pulses want 0", en); end
        checks++; if (bus.cmd_err !== 1'b0) begin errors++; $display("FAIL nokey_cmd_err_width: got %b want 0", bus.cmd_err); end
    endtask

    task automatic test_key_expand();
        int low = 0;
        int kp = 0;
        int sbad = 0;
        key_lat = 20;
        drive_cmd(1'b1, 1'b0);
        checks++; if (bus.key_init !== 1'b1) begin errors++; $display("FAIL key_init_latency: got %b want 1", bus.key_init); end
        while (bus.ready === 1'b0 && low < 100) begin
            low++;
            if (bus.key_init === 1'b1) kp++;
            if (bus.sboxw !== 32'hdeadbeef) sbad++;
            @(negedge clk);
        end
        checks++; if (low != 22) begin errors++; $display("FAIL key_busy_cycles: got %0d want 22", low); end
        checks++; if (kp != 1) begin errors++; $display("FAIL key_init_pulses: got %0d want 1", kp); end
        checks++; if (sbad != 0) begin errors++; $display("FAIL key_sboxw_track: got %0d bad cycles want 0", sbad); end
        checks++; if (bus.sboxw !== 32'h01234567) begin errors++; $display("FAIL idle_sboxw: got %h want 01234567", bus.sboxw); end
    endtask

    task automatic test_encrypt();
        int n = 0;
        int sbad = 0;
        int rvbad = 0;
        enc_lat = 52;
        blk_vec = FIPS_CT;
        drive_cmd(1'b0, 1'b1);
        checks++; if (bus.enc_next !== 1'b1 || bus.cmd_err !== 1'b0) begin errors++; $display("FAIL enc_start: got enc_next=%b cmd_err=%b want 1 0", bus.enc_next, bus.cmd_err); end
        @(negedge clk);
        while (bus.enc_ready === 1'b0 && n < 200) begin
            n++;
            if (bus.sboxw !== 32'h01234567) sbad++;
            if (bus.result_valid !== 1'b0) rvbad++;
            @(negedge clk);
        end
        checks++; if (n != 52) begin errors++; $display("FAIL enc_busy_cycles: got %0d want 52", n); end
        checks++; if (sbad != 0 || rvbad != 0) begin errors++; $display("FAIL enc_wait_outputs: got sbox_bad=%0d rv_bad=%0d want 0 0", sbad, rvbad); end
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL enc_rv_early: got %b want 0", bus.result_valid); end
        @(negedge clk);
        checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL enc_rv_rise: got %b want 1", bus.result_valid); end
        checks++; if (bus.result !== FIPS_CT) begin errors++; $display("FAIL enc_result: got %h want %h", bus.result, FIPS_CT); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL enc_ready_after: got %b want 1", bus.ready); end
    endtask

    task automatic test_init_next_pending();
        int n = 0;
        int rbad = 0;
        int extra = 0;
        key_lat = 5;
        enc_lat = 4;
        blk_vec = C1_CT;
        drive_cmd(1'b1, 1'b1);
        checks++; if (bus.key_init !== 1'b1 || bus.enc_next !== 1'b0) begin errors++; $display("FAIL both_key_first: got key_init=%b enc_next=%b want 1 0", bus.key_init, bus.enc_next); end
        while (bus.enc_next !== 1'b1 && n < 50) begin
            n++;
            if (bus.ready !== 1'b0) rbad++;
            @(negedge clk);
        end
        checks++; if (n != 7 || rbad != 0) begin errors++; $display("FAIL both_auto_enc: got %0d cycles ready_bad=%0d want 7 0", n, rbad); end
        @(negedge clk);
        bus.next = 1'b1;
        @(negedge clk);
        checks++; if (bus.cmd_err !== 1'b0) begin errors++; $display("FAIL busy_next_pending: got cmd_err=%b want 0", bus.cmd_err); end
        @(negedge clk);
        bus.next = 1'b0;
        checks++; if (bus.cmd_err !== 1'b1) begin errors++; $display("FAIL busy_next_overflow: got cmd_err=%b want 1", bus.cmd_err); end
        n = 0;
        while (bus.enc_next !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != 3) begin errors++; $display("FAIL pending_enc_reissue: got %0d cycles want 3", n); end
        checks++; if (bus.result_valid !== 1'b1 || bus.result !== C1_CT) begin errors++; $display("FAIL pending_first_result: got rv=%b result=%h want 1 %h", bus.result_valid, bus.result, C1_CT); end
        @(negedge clk);
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL pending_rv_clear: got %b want 0", bus.result_valid); end
        n = 0;
        while (bus.ready !== 1'b1 && n < 20) begin
            n++;
            if (bus.enc_next === 1'b1) extra++;
            @(negedge clk);
        end
        checks++; if (bus.ready !== 1'b1 || extra != 0 || bus.result_valid !== 1'b1) begin errors++; $display("FAIL pending_drain: got ready=%b extra=%0d rv=%b want 1 0 1", bus.ready, extra, bus.result_valid); end
    endtask

    task automatic test_init_while_busy();
        int kp = 0;
        key_lat = 6;
        drive_cmd(1'b1, 1'b0);
        @(negedge clk);
        bus.init = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        checks++; if (bus.cmd_err !== 1'b1 || bus.key_init !== 1'b0) begin errors++; $display("FAIL busy_init_reject: got cmd_err=%b key_init=%b want 1 0", bus.cmd_err, bus.key_init); end
        for (int i = 0; i < 30 && bus.ready !== 1'b1; i++) begin
            if (bus.key_init === 1'b1) kp++;
            @(negedge clk);
        end
        checks++; if (bus.ready !== 1'b1 || kp != 0) begin errors++; $display("FAIL busy_init_ignored: got ready=%b key_init_pulses=%0d want 1 0", bus.ready, kp); end
    endtask

    task automatic test_enc_timeout();
        int n = 0;
        int rbad = 0;
        enc_hang = 1'b1;
        blk_vec = FIPS_CT;
        drive_cmd(1'b0, 1'b1);
        checks++; if (bus.enc_next !== 1'b1) begin errors++; $display("FAIL tmo_enc_start: got %b want 1", bus.enc_next); end
        @(negedge clk);
        while (bus.cmd_err !== 1'b1 && n < 400) begin
            n++;
            if (bus.ready !== 1'b0) rbad++;
            @(negedge clk);
        end
        checks++; if (n != 255 || rbad != 0) begin errors++; $display("FAIL enc_timeout_cycles: got %0d ready_bad=%0d want 255 0", n, rbad); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL enc_timeout_idle: got ready=%b want 1", bus.ready); end
        @(negedge clk);
        checks++; if (bus.cmd_err !== 1'b0) begin errors++; $display("FAIL enc_timeout_pulse: got %b want 0", bus.cmd_err); end
        enc_hang = 1'b0;
        enc_lat = 3;
        drive_cmd(1'b0, 1'b1);
        checks++; if (bus.enc_next !== 1'b1) begin errors++; $display("FAIL enc_timeout_key_kept: got enc_next=%b want 1", bus.enc_next); end
        wait_ready(20);
        checks++; if (bus.ready !== 1'b1 || bus.result !== FIPS_CT) begin errors++; $display("FAIL enc_after_timeout: got ready=%b result=%h want 1 %h", bus.ready, bus.result, FIPS_CT); end
    endtask

    task automatic test_key_timeout();
        int n = 0;
        key_hang = 1'b1;
        drive_cmd(1'b1, 1'b0);
        @(negedge clk);
        while (bus.cmd_err !== 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != 255 || bus.ready !== 1'b1) begin errors++; $display("FAIL key_timeout: got %0d cycles ready=%b want 255 1", n, bus.ready); end
        key_hang = 1'b0;
        @(negedge clk);
        drive_cmd(1'b0, 1'b1);
        checks++; if (bus.cmd_err !== 1'b1 || bus.enc_next !== 1'b0) begin errors++; $display("FAIL key_timeout_invalid: got cmd_err=%b enc_next=%b want 1 0", bus.cmd_err, bus.enc_next); end
        key_lat = 3;
        drive_cmd(1'b1, 1'b0);
        wait_ready(20);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rekey_done: got ready=%b want 1", bus.ready); end
    endtask

    task automatic test_reset_mid();
        enc_lat = 52;
        checks++; if (bus.result !== FIPS_CT) begin errors++; $display("FAIL result_hold: got %h want %h", bus.result, FIPS_CT); end
        drive_cmd(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL mid_busy: got ready=%b want 0", bus.ready); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.ready !== 1'b1 || bus.result_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got ready=%b rv=%b want 1 0", bus.ready, bus.result_valid); end
        checks++; if (bus.result !== 128'h0) begin errors++; $display("FAIL mid_reset_result: got %h want 0", bus.result); end
        drive_cmd(1'b0, 1'b1);
        checks++; if (bus.cmd_err !== 1'b1 || bus.enc_next !== 1'b0) begin errors++; $display("FAIL mid_reset_key_cleared: got cmd_err=%b enc_next=%b want 1 0", bus.cmd_err, bus.enc_next); end
    endtask

    initial begin
        bus.init = 1'b0;
        bus.next = 1'b0;
        bus.key_sboxw = 32'hdeadbeef;
        bus.enc_sboxw = 32'h01234567;
        test_reset();
        test_next_no_key();
        test_key_expand();
        test_encrypt();
        test_init_next_pending();
        test_init_while_busy();
        test_enc_timeout();
        test_key_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_core_ctrl.md
Name: aes_core_ctrl

Overview:
Top-level sequencer for the AES-128 encryption core. It accepts host init/next commands, runs key expansion and then encryption in order, and captures the 128-bit result. It also time-shares the single 32-bit S-box between the key memory and the encipher block. It sits between the host register interface and the key-memory, encipher and sbox instances.

Parameters:
TIMEOUT_CYCLES, 255, max cycles a downstream block may stay busy before the controller aborts with an error (1..255).

Ports:
clk  in  1  core clock, rising edge
reset  in  1  synchronous, active-high reset
init  in  1  host: start key expansion (single-cycle pulse)
next  in  1  host: encrypt current block (single-cycle pulse)
ready  out  1  controller idle, no pending command
result_valid  out  1  result holds a block encrypted under the current key
cmd_err  out  1  one-cycle pulse: command rejected or timeout
result  out  128  captured ciphertext
key_init  out  1  one-cycle start pulse to key memory
key_ready  in  1  key memory idle/done
enc_next  out  1  one-cycle start pulse to encipher block
enc_ready  in  1  encipher idle/done
enc_new_block  in  128  encipher output block
key_sboxw  in  32  key memory S-box request word
enc_sboxw  in  32  encipher S-box request word
sboxw  out  32  muxed word to the shared S-box

Behaviour:
- Reset values: ready=1, result_valid=0, cmd_err=0, result=0, key_init=0, enc_next=0, FSM=IDLE, key_valid=0, pending=0, timeout counter=0.
- Reset mid-operation aborts everything in the same cycle.
- FSM states: IDLE, KEY_START, KEY_WAIT, ENC_START, ENC_WAIT.
- IDLE:
  - init -> KEY_START.
  - else next with key_valid=1 -> ENC_START.
  - next with key_valid=0 -> cmd_err pulse, stay in IDLE.
- KEY_START:
  - key_init=1 for exactly one cycle, clear key_valid and result_valid, then KEY_WAIT.
- KEY_WAIT:
  - key_ready=1 -> set key_valid. Go to ENC_START if pending=1 (clearing pending), else IDLE.
- ENC_START:
  - enc_next=1 for exactly one cycle, clear result_valid, then ENC_WAIT.
- ENC_WAIT:
  - enc_ready=1 -> result<=enc_new_block, result_valid<=1. Go to ENC_START if pending=1 (clearing pending), else IDLE.
- Downstream handshake: downstream ready drops in the cycle after the start pulse, so the WAIT states sample ready directly with no guard cycle.
- Command priority:
  - init and next in the same cycle in IDLE -> init taken, next latched as pending.
- Commands while busy (any non-IDLE state):
  - next -> latched into pending if pending=0, else cmd_err.
  - init -> cmd_err, ignored.
- ready output:
  - ready=1 only in IDLE with pending=0. It is combinational from registered state.
  - ready drops in the cycle after an accepted command.
- Timeout:
  - 8-bit counter cleared on entry to a WAIT state, incremented each WAIT cycle.
  - Reaching TIMEOUT_CYCLES -> cmd_err pulse, clear pending, key_valid=0 if in KEY_WAIT, go to IDLE.
- S-box mux (combinational):
  - sboxw=key_sboxw in KEY_START/KEY_WAIT, else enc_sboxw.
- Latency:
  - next in IDLE -> enc_next asserted 1 cycle later.
  - result_valid rises the cycle after enc_ready is seen high in ENC_WAIT.
- result holds its value until the next ENC_WAIT completion or reset.

Decomposition:
- Shared package aes_pkg holds:
  - FSM state encodings (3-bit CTRL_IDLE..CTRL_ENC_WAIT);
  - AES128_ROUNDS = 4'ha;
  - the block width constant 128.
- Natural sub-module: aes_sbox_mux (2:1 32-bit S-box requester select). The FSM and timeout counter stay in aes_core_ctrl.

Test Plan:
- Reset then next with no init -> cmd_err pulse one cycle after next; ready stays 1; enc_next never asserted.
- init, key model returns key_ready after 20 cycles -> key_init pulses once; ready=0 for 22 cycles; key_valid set; sboxw tracks key_sboxw=32'hdeadbeef throughout.
- After key valid: next, encipher model completes after 52 cycles with FIPS-197 vector 3925841d02dc09fbdc118597196a0b32 -> result equals that value; result_valid=1 the cycle after enc_ready; sboxw tracks enc_sboxw.
- init and next in the same cycle -> key sequence runs first, then enc_next auto-issued with no host action; a second next while busy -> pending; a third -> cmd_err.
- Encipher model never raises enc_ready -> cmd_err after exactly 255 WAIT cycles; FSM returns to IDLE; ready=1.
- Reset asserted mid-ENC_WAIT -> next cycle ready=1, result_valid=0, result=0, key_valid=0; a following next gives cmd_err.
